// File: rtl/seq_pkg.sv
// Shared definitions for the ALU issue sequencer: FSM encoding and instruction field widths.
package seq_pkg;

   localparam int unsigned OP_W    = 4;
   localparam int unsigned FUNCT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   // Packed word is {op, funct, rs, rt, rd}
   function automatic int unsigned instr_w(input int unsigned reg_addr_w);
      return OP_W + FUNCT_W + 3 * reg_addr_w;
   endfunction

endpackage

// File: rtl/fifo_instr.sv
// Registered instruction FIFO, no fall-through; a push is refused when full even if a pop happens.
module fifo_instr #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 26
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_count == CNT_W'(DEPTH));
   assign empty  = (r_count == '0);
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign rdata  = r_mem[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= wdata;
   end

endmodule

// File: rtl/sequenciador_ula.sv
// Multi-cycle issue controller: buffers R-type micro-instructions and runs each as EXEC then WRITE.
// Optional SEQ_INSTR_COUNT_EN adds retire and suppressed-write-back counters.
module sequenciador_ula
   import seq_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 6
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [OP_W-1:0]       instr_alu_op,
   input  logic [FUNCT_W-1:0]    instr_funct,
   input  logic [REG_ADDR_W-1:0] instr_rs,
   input  logic [REG_ADDR_W-1:0] instr_rt,
   input  logic [REG_ADDR_W-1:0] instr_rd,
   output logic [OP_W-1:0]       alu_op,
   output logic [FUNCT_W-1:0]    funct,
   output logic [REG_ADDR_W-1:0] rs,
   output logic [REG_ADDR_W-1:0] rt,
   output logic [REG_ADDR_W-1:0] rd,
   output logic                  enable,
   output logic                  reg_write,
   input  logic                  zero_in,
   input  logic [DATA_W-1:0]     result_in,
   output logic                  done,
   output logic [DATA_W-1:0]     result,
   output logic                  zero_flag,
   output logic                  busy
`ifdef SEQ_INSTR_COUNT_EN
   ,
   output logic [15:0]           instr_count,
   output logic [15:0]           wb_suppressed
`endif
);

   localparam int unsigned INSTR_W = instr_w(REG_ADDR_W);

   typedef struct packed {
      logic [OP_W-1:0]       op;
      logic [FUNCT_W-1:0]    fn;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
   } instr_t;

   state_t                r_state;
   logic [OP_W-1:0]       r_alu_op;
   logic [FUNCT_W-1:0]    r_funct;
   logic [REG_ADDR_W-1:0] r_rs;
   logic [REG_ADDR_W-1:0] r_rt;
   logic [REG_ADDR_W-1:0] r_rd;
   logic                  r_enable;
   logic                  r_reg_write;
   logic                  r_done;
   logic [DATA_W-1:0]     r_result;
   logic                  r_zero;

   instr_t                w_push_word;
   instr_t                w_head;
   logic [INSTR_W-1:0]    w_rdata;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;

   assign w_push_word = '{op: instr_alu_op, fn: instr_funct, rs: instr_rs, rt: instr_rt, rd: instr_rd};
   assign w_head      = instr_t'(w_rdata);
   assign w_pop       = !w_empty && ((r_state == ST_IDLE) || (r_state == ST_WRITE));

   fifo_instr #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (INSTR_W)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (instr_valid),
      .wdata   (INSTR_W'(w_push_word)),
      .pop     (w_pop),
      .rdata   (w_rdata),
      .full    (w_full),
      .empty   (w_empty)
   );

   // Sequencer: a pop loads the fields and enters EXEC; WRITE retires and may chain straight into EXEC
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_alu_op    <= '0;
         r_funct     <= '0;
         r_rs        <= '0;
         r_rt        <= '0;
         r_rd        <= '0;
         r_enable    <= 1'b0;
         r_reg_write <= 1'b0;
         r_done      <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_enable    <= 1'b0;
               r_reg_write <= 1'b0;
               if (!w_empty) begin
                  r_alu_op <= w_head.op;
                  r_funct  <= w_head.fn;
                  r_rs     <= w_head.rs;
                  r_rt     <= w_head.rt;
                  r_rd     <= w_head.rd;
                  r_enable <= 1'b1;
                  r_state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_enable    <= 1'b1;
               r_reg_write <= (r_rd != '0);
               r_state     <= ST_WRITE;
            end
            ST_WRITE: begin
               r_result    <= result_in;
               r_zero      <= zero_in;
               r_done      <= 1'b1;
               r_reg_write <= 1'b0;
               if (!w_empty) begin
                  r_alu_op <= w_head.op;
                  r_funct  <= w_head.fn;
                  r_rs     <= w_head.rs;
                  r_rt     <= w_head.rt;
                  r_rd     <= w_head.rd;
                  r_enable <= 1'b1;
                  r_state  <= ST_EXEC;
               end else begin
                  r_enable <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: begin
               r_enable    <= 1'b0;
               r_reg_write <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SEQ_INSTR_COUNT_EN
   logic [15:0] r_instr_count;
   logic [15:0] r_wb_suppressed;

   // Both counters advance on the retire edge and wrap at 16 bits
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_instr_count   <= '0;
         r_wb_suppressed <= '0;
      end else if (r_state == ST_WRITE) begin
         r_instr_count <= r_instr_count + 16'd1;
         if (r_rd == '0) r_wb_suppressed <= r_wb_suppressed + 16'd1;
      end
   end

   assign instr_count   = r_instr_count;
   assign wb_suppressed = r_wb_suppressed;
`endif

   assign instr_ready = !w_full;
   assign busy        = (r_state != ST_IDLE) || !w_empty;
   assign alu_op      = r_alu_op;
   assign funct       = r_funct;
   assign rs          = r_rs;
   assign rt          = r_rt;
   assign rd          = r_rd;
   assign enable      = r_enable;
   assign reg_write   = r_reg_write;
   assign done        = r_done;
   assign result      = r_result;
   assign zero_flag   = r_zero;

endmodule

// File: tb/tb_sequenciador_ula.sv
// Bench for sequenciador_ula: random and directed instruction streams against an issue-schedule model.
module tb_sequenciador_ula;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 6;

   typedef struct packed {
      logic [3:0]    op;
      logic [3:0]    fn;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] rd;
   } ins_t;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          instr_valid;
   logic          instr_ready;
   logic [3:0]    instr_alu_op, instr_funct;
   logic [AW-1:0] instr_rs, instr_rt, instr_rd;
   logic [3:0]    alu_op, funct;
   logic [AW-1:0] rs, rt, rd;
   logic          enable, reg_write;
   logic          zero_in;
   logic [DW-1:0] result_in;
   logic          done;
   logic [DW-1:0] result;
   logic          zero_flag;
   logic          busy;
`ifdef SEQ_INSTR_COUNT_EN
   logic [15:0]   instr_count, wb_suppressed;
   logic [15:0]   exp_cnt, exp_sup;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n       = 0;
   ins_t m_ins[$];
   int   m_p[$];
   int   m_d[$];
   int   last_d;
   logic [DW-1:0] last_res;
   logic          last_zero;

   sequenciador_ula #(.FIFO_DEPTH(DEPTH), .DATA_W(DW), .REG_ADDR_W(AW)) dut (
      .clock(clock), .reset_n(reset_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_alu_op(instr_alu_op), .instr_funct(instr_funct),
      .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
      .alu_op(alu_op), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
      .enable(enable), .reg_write(reg_write),
      .zero_in(zero_in), .result_in(result_in),
      .done(done), .result(result), .zero_flag(zero_flag), .busy(busy)
`ifdef SEQ_INSTR_COUNT_EN
      , .instr_count(instr_count), .wb_suppressed(wb_suppressed)
`endif
   );

   always #5 clock = ~clock;
   always @(posedge clock) n <= n + 1;

   // Datapath stub: result depends on the presented operands; op 4'hF yields zero
   function automatic logic [DW-1:0] stub_f(input logic [3:0] op, input logic [3:0] fn,
                                            input logic [AW-1:0] a, input logic [AW-1:0] b);
      if (op == 4'hF) return '0;
      return {12'h5A3, op, fn, a, b};
   endfunction

   always_comb begin
      result_in = stub_f(alu_op, funct, rs, rt);
      zero_in   = (result_in == '0);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %h expected %h", tag, n, got, exp);
      end
   endtask

   function automatic ins_t rand_ins();
      ins_t t;
      t.op = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
      t.fn = 4'($urandom);
      t.rs = AW'($urandom);
      t.rt = AW'($urandom);
      t.rd = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
      return t;
   endfunction

   function automatic ins_t mk(input logic [3:0] op, input logic [3:0] fn,
                               input int a, input int b, input int d);
      ins_t t;
      t.op = op; t.fn = fn; t.rs = AW'(a); t.rt = AW'(b); t.rd = AW'(d);
      return t;
   endfunction

   task automatic model_clear();
      m_ins.delete(); m_p.delete(); m_d.delete();
      last_d    = -100;
      last_res  = '0;
      last_zero = 1'b0;
`ifdef SEQ_INSTR_COUNT_EN
      exp_cnt = '0;
      exp_sup = '0;
`endif
   endtask

   // Compare every output against the schedule: pop edge D -> EXEC cycle D, WRITE D+1, done D+2
   task automatic check_outputs();
      int  k_write = -1;
      int  k_done  = -1;
      bit  in_exec = 0;
      int  occ     = 0;
      ins_t t;
      foreach (m_d[i]) begin
         if (m_d[i] == n)     in_exec = 1;
         if (m_d[i] + 1 == n) k_write = i;
         if (m_d[i] + 2 == n) k_done  = i;
         if (m_p[i] <= n) occ++;
         if (m_d[i] <= n) occ--;
      end
      if (k_done >= 0) begin
         t         = m_ins[k_done];
         last_res  = stub_f(t.op, t.fn, t.rs, t.rt);
         last_zero = (last_res == '0);
`ifdef SEQ_INSTR_COUNT_EN
         exp_cnt = exp_cnt + 16'd1;
         if (t.rd == '0) exp_sup = exp_sup + 16'd1;
`endif
      end
      check_val("enable", 32'(enable), 32'(in_exec || k_write >= 0));
      check_val("reg_write", 32'(reg_write), 32'(k_write >= 0 && m_ins[k_write].rd != '0));
      check_val("done", 32'(done), 32'(k_done >= 0));
      check_val("result", result, last_res);
      check_val("zero_flag", 32'(zero_flag), 32'(last_zero));
      check_val("instr_ready", 32'(instr_ready), 32'(occ < int'(DEPTH)));
      check_val("busy", 32'(busy), 32'(occ > 0 || in_exec || k_write >= 0));
      if (k_write >= 0) begin
         t = m_ins[k_write];
         check_val("wb_fields", {8'h0, alu_op, funct, rs, rt, rd}, {8'h0, t.op, t.fn, t.rs, t.rt, t.rd});
      end
`ifdef SEQ_INSTR_COUNT_EN
      check_val("instr_count", 32'(instr_count), 32'(exp_cnt));
      check_val("wb_suppressed", 32'(wb_suppressed), 32'(exp_sup));
`endif
   endtask

   // One cycle: check at the negedge, then present the next request for the coming edge
   task automatic tick(input bit v, input ins_t t);
      int occ = 0;
      int p;
      check_outputs();
      foreach (m_d[i]) begin
         if (m_p[i] <= n) occ++;
         if (m_d[i] <= n) occ--;
      end
      instr_valid  = v;
      instr_alu_op = t.op; instr_funct = t.fn;
      instr_rs = t.rs; instr_rt = t.rt; instr_rd = t.rd;
      if (v && occ < int'(DEPTH)) begin
         p      = n + 1;
         last_d = (p + 1 > last_d + 2) ? p + 1 : last_d + 2;
         m_ins.push_back(t); m_p.push_back(p); m_d.push_back(last_d);
      end
      @(negedge clock);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) tick(1'b0, '0);
   endtask

   task automatic check_reset_state();
      check_val("rst_reg_write", 32'(reg_write), 32'd0);
      check_val("rst_enable", 32'(enable), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_result", result, '0);
      check_val("rst_ready", 32'(instr_ready), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      instr_valid = 1'b0;
      instr_alu_op = '0; instr_funct = '0; instr_rs = '0; instr_rt = '0; instr_rd = '0;
      model_clear();
      #1 check_reset_state();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      // Single instruction
      tick(1'b1, mk(4'h2, 4'h0, 1, 2, 3));
      idle(6);

      // Back-to-back stream of three
      tick(1'b1, mk(4'h1, 4'h3, 4, 5, 6));
      tick(1'b1, mk(4'h4, 4'h1, 7, 8, 9));
      tick(1'b1, mk(4'h6, 4'h2, 10, 11, 12));
      idle(10);

      // Saturate the FIFO: request held for 8 cycles
      for (int i = 0; i < 8; i++) tick(1'b1, rand_ins());
      idle(20);

      // rd==0 producing a zero result
      tick(1'b1, mk(4'hF, 4'h0, 3, 3, 0));
      idle(6);

      // Random traffic
      for (int i = 0; i < 400; i++) tick($urandom_range(0, 2) != 0, rand_ins());
      idle(20);

`ifdef SEQ_INSTR_COUNT_EN
      force dut.r_instr_count = 16'hFFFF;
      #1 release dut.r_instr_count;
      exp_cnt = 16'hFFFF;
      tick(1'b1, rand_ins());
      idle(6);
`endif

      // Reset asserted while the instruction is in WRITE
      tick(1'b1, mk(4'h3, 4'h5, 2, 9, 7));
      idle(2);
      check_val("pre_rst_reg_write", 32'(reg_write), 32'd1);
      #2 reset_n = 1'b0;
      instr_valid = 1'b1;
      #1 check_reset_state();
      model_clear();
      @(negedge clock);
      instr_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      check_reset_state();
      idle(3);
      tick(1'b1, mk(4'h7, 4'h7, 1, 1, 1));
      idle(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
